// File: rtl/sc_pkg.sv
// Shared stochastic-computing definitions: FSM states, default sizes and a
// bit-reverse helper for pairing normal/flipped LFSR words.
package sc_pkg;

  localparam int unsigned SC_W          = 8;
  localparam int unsigned SC_STREAM_LEN = 255;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } sc_state_e;

  function automatic logic [SC_W-1:0] bit_reverse(input logic [SC_W-1:0] x);
    logic [SC_W-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < SC_W; i++) r[i] = x[SC_W-1-i];
    return r;
  endfunction

endpackage

// File: rtl/sc_sng.sv
// Stochastic number generator: one registered stream bit per cycle, set when
// the random word falls below the operand value.
module sc_sng
  import sc_pkg::*;
#(
  parameter int unsigned W = SC_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic [W-1:0] rnd,
  input  logic [W-1:0] value,
  output logic         stream_bit
);

  always_ff @(posedge clk) begin
    if (reset) stream_bit <= 1'b0;
    else       stream_bit <= en && (rnd < value);
  end

endmodule

// File: rtl/sc_mult_stream.sv
// Stochastic multiplier: ANDs two unipolar bitstreams for STREAM_LEN cycles and
// reports the count of ones as the binary product estimate.
module sc_mult_stream
  import sc_pkg::*;
#(
  parameter int unsigned W          = SC_W,
  parameter int unsigned STREAM_LEN = SC_STREAM_LEN
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] rnd_a,
  input  logic [W-1:0] rnd_b,
  output logic         busy,
  output logic         bit_valid,
  output logic         bit_a,
  output logic         bit_b,
  output logic         bit_y,
  output logic         done,
  output logic [W-1:0] result
);

  localparam logic [W-1:0] LAST = W'(STREAM_LEN - 1);

  sc_state_e    state_q, state_d;
  logic         run;
  logic [W-1:0] a_q, b_q, ones_cnt, len_cnt;

  sc_sng #(.W(W)) u_sng_a (
    .clk(clk), .reset(reset), .en(run), .rnd(rnd_a), .value(a_q), .stream_bit(bit_a)
  );

  sc_sng #(.W(W)) u_sng_b (
    .clk(clk), .reset(reset), .en(run), .rnd(rnd_b), .value(b_q), .stream_bit(bit_b)
  );

  always_comb begin
    state_d = state_q;
    run     = (state_q == RUN);
    busy    = run;
    bit_y   = bit_a & bit_b;
    unique case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (len_cnt == LAST) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Stream bits are registered, so ones_cnt lags by one cycle; the last bit is
  // folded in when the result is captured in DONE.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_q       <= '0;
      b_q       <= '0;
      ones_cnt  <= '0;
      len_cnt   <= '0;
      bit_valid <= 1'b0;
      done      <= 1'b0;
      result    <= '0;
    end else begin
      done      <= 1'b0;
      bit_valid <= run;
      unique case (state_q)
        IDLE: if (start) begin
          a_q      <= a;
          b_q      <= b;
          ones_cnt <= '0;
          len_cnt  <= '0;
        end
        RUN: begin
          len_cnt  <= len_cnt + W'(1);
          ones_cnt <= ones_cnt + W'(bit_y);
        end
        DONE: begin
          result <= ones_cnt + W'(bit_y);
          done   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sc_mult_stream.sv
// Scoreboard bench for sc_mult_stream: counter and random rnd streams, expected
// bits/results from a counting model, checked by an independent monitor.
module tb_sc_mult_stream;
  import sc_pkg::*;

  localparam int unsigned W = 8;
  localparam int unsigned L = 255;

  logic         clk = 1'b0;
  logic         reset, start;
  logic [W-1:0] a, b, rnd_a, rnd_b;
  logic         busy, bit_valid, bit_a, bit_b, bit_y, done;
  logic [W-1:0] result;

  always #5 clk = ~clk;

  sc_mult_stream #(.W(W), .STREAM_LEN(L)) dut (
    .clk(clk), .reset(reset), .start(start), .a(a), .b(b),
    .rnd_a(rnd_a), .rnd_b(rnd_b), .busy(busy), .bit_valid(bit_valid),
    .bit_a(bit_a), .bit_b(bit_b), .bit_y(bit_y), .done(done), .result(result)
  );

  int unsigned  n_cmp = 0, n_bad = 0;
  logic [W-1:0] seq_a [L];
  logic [W-1:0] seq_b [L];
  int unsigned  res_q[$];
  logic [2:0]   bit_q[$];
  int unsigned  held_exp = 0;
  int unsigned  idx = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Plays the current stream's words into the DUT, one per RUN cycle.
  always @(negedge clk) begin
    if (busy && idx < L) begin
      rnd_a = seq_a[idx];
      rnd_b = seq_b[idx];
      idx++;
    end else if (!busy) begin
      idx   = 0;
      rnd_a = W'($urandom);
      rnd_b = W'($urandom);
    end
  end

  always @(posedge clk) begin
    #1;
    if (!reset) begin
      if (bit_valid) begin
        if (bit_q.size() == 0) check("unexpected_bit_valid", 1, 0);
        else begin
          logic [2:0] e;
          e = bit_q.pop_front();
          check("bit_a", bit_a, e[2]);
          check("bit_b", bit_b, e[1]);
          check("bit_y", bit_y, e[0]);
        end
      end
      if (done) begin
        if (res_q.size() == 0) check("unexpected_done", 1, 0);
        else begin
          held_exp = res_q.pop_front();
          check("result", result, held_exp);
        end
      end else begin
        check("result_hold", result, held_exp);
      end
    end
  end

  task automatic issue(input logic [W-1:0] av, input logic [W-1:0] bv, input bit rand_rnd);
    int unsigned ones;
    bit sa, sb;
    ones = 0;
    for (int k = 0; k < L; k++) begin
      if (rand_rnd) begin
        seq_a[k] = W'($urandom);
        seq_b[k] = W'($urandom);
      end else begin
        seq_a[k] = W'(k + 1);
        seq_b[k] = bit_reverse(seq_a[k]);
      end
      sa = (seq_a[k] < av);
      sb = (seq_b[k] < bv);
      ones += (sa && sb) ? 1 : 0;
      bit_q.push_back({sa, sb, sa && sb});
    end
    res_q.push_back(ones);
    @(negedge clk);
    check("idle_before_start", busy, 0);
    a = av;
    b = bv;
    start = 1'b1;
  endtask

  // Follows one stream to done; optional mid-RUN start pulse and reset.
  task automatic run_stream(input logic [W-1:0] av, input logic [W-1:0] bv,
                            input bit rand_rnd, input int unsigned reset_at);
    int unsigned n;
    issue(av, bv, rand_rnd);
    n = 0;
    while (1) begin
      @(posedge clk);
      #1;
      n++;
      if (n == 1) begin
        start = 1'b0;
        a = W'($urandom);
        b = W'($urandom);
      end
      if (done) break;
      check("busy", busy, (n <= L) ? 1 : 0);
      if (reset_at != 0 && n == 50) start = 1'b1;
      if (reset_at != 0 && n == 51) start = 1'b0;
      if (reset_at != 0 && n == reset_at) begin
        @(negedge clk);
        reset = 1'b1;
        bit_q.delete();
        res_q.delete();
        held_exp = 0;
        @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_result", result, 0);
        check("rst_bit_valid", bit_valid, 0);
        @(negedge clk);
        reset = 1'b0;
        return;
      end
      if (n > L + 10) begin
        check("done_timeout", n, L + 2);
        return;
      end
    end
    check("latency", n, L + 2);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    a = '0;
    b = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", busy, 0);
    check("reset_bit_valid", bit_valid, 0);
    check("reset_bit_a", bit_a, 0);
    check("reset_bit_b", bit_b, 0);
    check("reset_bit_y", bit_y, 0);
    check("reset_done", done, 0);
    check("reset_result", result, 0);
    @(negedge clk);
    reset = 1'b0;

    run_stream(8'd0,   8'd255, 1'b0, 0);
    run_stream(8'd255, 8'd255, 1'b0, 0);
    run_stream(8'd128, 8'd255, 1'b0, 0);
    run_stream(8'd128, 8'd128, 1'b0, 0);

    run_stream(8'd200, 8'd100, 1'b0, 100);
    run_stream(8'd200, 8'd100, 1'b0, 0);

    run_stream(W'($urandom), W'($urandom), 1'b0, 0);
    run_stream(W'($urandom), W'($urandom), 1'b0, 0);

    for (int i = 0; i < 6; i++) run_stream(W'($urandom), W'($urandom), 1'b1, 0);
    run_stream(8'd255, 8'd1, 1'b1, 0);

    repeat (5) @(posedge clk);
    #1;
    check("bits_left", bit_q.size(), 0);
    check("results_left", res_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
